// File: rtl/debounced_button_bank.sv
// Multi-channel button debouncer: 2-flop sync, per-channel stability counter, level + press/release strobes.
// Latency: clean input step reaches ButtonOut 2+STABLE_CYCLES edges later; AnyPressed lags ButtonOut by one.
// No backpressure; optional hold/auto-repeat press strobes under DEBOUNCED_BUTTON_AUTO_REPEAT_EN.
module debounced_button_bank #(
  parameter int N_BUTTONS     = 4,
  parameter int STABLE_CYCLES = 100000,
  parameter int ACTIVE_LOW    = 0,
`ifdef DEBOUNCED_BUTTON_AUTO_REPEAT_EN
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
`endif
  parameter int CNT_W         = $clog2(STABLE_CYCLES+1)
) (
  input  logic                 c50M,
  input  logic                 Reset,
  input  logic [N_BUTTONS-1:0] Button,
  output logic [N_BUTTONS-1:0] ButtonOut,
  output logic [N_BUTTONS-1:0] PressPulse,
  output logic [N_BUTTONS-1:0] ReleasePulse,
  output logic                 AnyPressed
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES-1);

  logic [N_BUTTONS-1:0] in_c;
  logic [N_BUTTONS-1:0] s1;
  logic [N_BUTTONS-1:0] s2;
  logic [CNT_W-1:0]     cnt [N_BUTTONS];
  logic [N_BUTTONS-1:0] done;
  logic [N_BUTTONS-1:0] rep_fire;

  assign in_c = (ACTIVE_LOW != 0) ? ~Button : Button;

  // done: the synchronised input has disagreed with the level long enough to flip it this edge
  always_comb begin
    done = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      done[i] = (s2[i] != ButtonOut[i]) && (cnt[i] == LAST);
    end
  end

  always_ff @(posedge c50M) begin
    if (Reset) begin
      s1           <= '0;
      s2           <= '0;
      ButtonOut    <= '0;
      PressPulse   <= '0;
      ReleasePulse <= '0;
      AnyPressed   <= 1'b0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1           <= in_c;
      s2           <= s1;
      AnyPressed   <= |ButtonOut;
      PressPulse   <= (done & ~ButtonOut) | rep_fire;
      ReleasePulse <= done & ButtonOut;
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (s2[i] == ButtonOut[i]) begin
          cnt[i] <= '0;
        end else if (done[i]) begin
          cnt[i]       <= '0;
          ButtonOut[i] <= s2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef DEBOUNCED_BUTTON_AUTO_REPEAT_EN
  localparam int HMAX   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HCNT_W = $clog2(HMAX+1);
  localparam logic [HCNT_W-1:0] HOLD_M1 = HCNT_W'(HOLD_CYCLES-1);
  localparam logic [HCNT_W-1:0] REP_M1  = HCNT_W'(REPEAT_CYCLES-1);

  logic [HCNT_W-1:0]    hcnt [N_BUTTONS];
  logic [N_BUTTONS-1:0] rep_ph;

  // A release edge suppresses any repeat that would coincide with it
  always_comb begin
    rep_fire = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      rep_fire[i] = ButtonOut[i] && !done[i] &&
                    (hcnt[i] == (rep_ph[i] ? REP_M1 : HOLD_M1));
    end
  end

  always_ff @(posedge c50M) begin
    if (Reset) begin
      rep_ph <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        hcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (!ButtonOut[i] || done[i]) begin
          hcnt[i]   <= '0;
          rep_ph[i] <= 1'b0;
        end else if (rep_fire[i]) begin
          hcnt[i]   <= '0;
          rep_ph[i] <= 1'b1;
        end else begin
          hcnt[i] <= hcnt[i] + HCNT_W'(1);
        end
      end
    end
  end
`else
  assign rep_fire = '0;
`endif

endmodule

// File: tb/tb_debounced_button_bank.sv
// Directed bench for debounced_button_bank with STABLE_CYCLES=4 (press/release 6 edges after an input step).
module tb_debounced_button_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'hF;
  logic [3:0] btn_al = 4'hF;
  logic [3:0] out, pp, rp, out_al, pp_al, rp_al;
  logic       any, any_al;
  int         n_chk = 0;
  int         n_fail = 0;

  always #10 clk = ~clk;

`ifdef DEBOUNCED_BUTTON_AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
  debounced_button_bank #(.N_BUTTONS(4), .STABLE_CYCLES(4), .ACTIVE_LOW(0),
                          .HOLD_CYCLES(10), .REPEAT_CYCLES(3)) dut (
    .c50M(clk), .Reset(rst), .Button(btn), .ButtonOut(out),
    .PressPulse(pp), .ReleasePulse(rp), .AnyPressed(any));
`else
  localparam bit REP = 1'b0;
  debounced_button_bank #(.N_BUTTONS(4), .STABLE_CYCLES(4), .ACTIVE_LOW(0)) dut (
    .c50M(clk), .Reset(rst), .Button(btn), .ButtonOut(out),
    .PressPulse(pp), .ReleasePulse(rp), .AnyPressed(any));
`endif

  debounced_button_bank #(.N_BUTTONS(4), .STABLE_CYCLES(4), .ACTIVE_LOW(1)) dut_al (
    .c50M(clk), .Reset(rst), .Button(btn_al), .ButtonOut(out_al),
    .PressPulse(pp_al), .ReleasePulse(rp_al), .AnyPressed(any_al));

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    int         n;
    logic [3:0] out;
    logic [3:0] pp;
    logic [3:0] rp;
    logic       any;
  } vec_t;

  vec_t tbl [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int  bad;
    logic exp_pp;

    // Each row: drive rst/btn, advance n edges, then expect out/pp/rp/any
    tbl[0]  = '{1'b1, 4'hF, 3,  4'h0, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 4'hF, 5,  4'h0, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 4'hF, 1,  4'hF, 4'hF, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 4'hF, 1,  4'hF, 4'h0, 4'h0, 1'b1};
    tbl[4]  = '{1'b0, 4'h0, 5,  4'hF, 4'h0, 4'h0, 1'b1};
    tbl[5]  = '{1'b0, 4'h0, 1,  4'h0, 4'h0, 4'hF, 1'b1};
    tbl[6]  = '{1'b0, 4'h0, 1,  4'h0, 4'h0, 4'h0, 1'b0};
    tbl[7]  = '{1'b0, 4'h1, 5,  4'h0, 4'h0, 4'h0, 1'b0};
    tbl[8]  = '{1'b0, 4'h1, 1,  4'h1, 4'h1, 4'h0, 1'b0};
    tbl[9]  = '{1'b0, 4'h1, 1,  4'h1, 4'h0, 4'h0, 1'b1};
    tbl[10] = '{1'b0, 4'h1, 14, 4'h1, 4'h0, 4'h0, 1'b1};
    tbl[11] = '{1'b0, 4'h0, 5,  4'h1, 4'h0, 4'h0, 1'b1};
    tbl[12] = '{1'b0, 4'h0, 1,  4'h0, 4'h0, 4'h1, 1'b1};
    tbl[13] = '{1'b0, 4'h0, 1,  4'h0, 4'h0, 4'h0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      rst = tbl[i].rst;
      btn = tbl[i].btn;
      repeat (tbl[i].n) tick();
      chk($sformatf("vec%0d_out", i), 32'(out), 32'(tbl[i].out));
      chk($sformatf("vec%0d_press", i), 32'(pp), 32'(tbl[i].pp));
      chk($sformatf("vec%0d_release", i), 32'(rp), 32'(tbl[i].rp));
      chk($sformatf("vec%0d_any", i), 32'(any), 32'(tbl[i].any));
    end
    chk("al_idle_out", 32'(out_al), 32'h0);
    chk("al_idle_any", 32'(any_al), 32'h0);

    // Bounce: runs of three highs never reach four stable cycles
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      btn[1] = (c % 4 != 3);
      tick();
      if (out[1] || pp[1] || rp[1]) bad++;
    end
    chk("bounce_quiet", 32'(bad), 32'h0);
    btn[1] = 1'b1;
    repeat (5) tick();
    chk("bounce_hold_e5", 32'(out), 32'h0);
    tick();
    chk("bounce_hold_out", 32'(out), 32'h2);
    chk("bounce_hold_press", 32'(pp), 32'h2);
    btn[1] = 1'b0;
    repeat (8) tick();
    chk("bounce_released", 32'(out), 32'h0);

    // Independence: ch3 glitches low for one cycle and restarts its count
    btn = 4'hC;
    tick();
    tick();
    btn[3] = 1'b0;
    tick();
    btn[3] = 1'b1;
    tick();
    tick();
    chk("indep_e5_out", 32'(out), 32'h0);
    tick();
    chk("indep_e6_out", 32'(out), 32'h4);
    chk("indep_e6_press", 32'(pp), 32'h4);
    tick();
    tick();
    chk("indep_e8_out", 32'(out), 32'h4);
    chk("indep_e8_press", 32'(pp), 32'h0);
    tick();
    chk("indep_e9_out", 32'(out), 32'hC);
    chk("indep_e9_press", 32'(pp), 32'h8);
    tick();
    chk("indep_e10_press", 32'(pp), 32'h0);

    // Long hold on ch0: single press, plus repeats at +10,+13,... when enabled
    btn = 4'h0;
    repeat (8) tick();
    chk("hold_pre_out", 32'(out), 32'h0);
    btn[0] = 1'b1;
    repeat (6) tick();
    chk("hold_k0_press", 32'(pp), 32'h1);
    for (int k = 1; k <= 45; k++) begin
      tick();
      exp_pp = REP && (k >= 10) && ((k - 10) % 3 == 0) && (k < 36);
      chk($sformatf("hold_k%0d_press", k), 32'(pp[0]), 32'(exp_pp));
      chk($sformatf("hold_k%0d_release", k), 32'(rp[0]), 32'(k == 36));
      if (k == 30) btn[0] = 1'b0;
    end
    chk("hold_end_out", 32'(out), 32'h0);

    // Active-low channel 0 press
    btn_al[0] = 1'b0;
    repeat (5) tick();
    chk("al_e5_out", 32'(out_al), 32'h0);
    tick();
    chk("al_e6_out", 32'(out_al), 32'h1);
    chk("al_e6_press", 32'(pp_al), 32'h1);
    tick();
    chk("al_e7_press", 32'(pp_al), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
